i2c_init_sequencer: RTL and testbench

Table-driven I2C configuration sequencer for the AR0134 sensor and the AD9889B HDMI transmitter. It walks a synchronous init ROM and expands each entry into byte-level commands for an I2C byte engine. Supported entries are register writes (8- or 16-bit register/data), millisecond delays and end-of-table. It sits between the init ROM and the shared I2C byte engine, so bring-up runs without the soft processor. It reports busy, done, error and the index of the failing entry.

---
 rtl/i2c_init_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_init_sequencer.sv
// Table-driven I2C init sequencer: walks a synchronous init ROM and expands
// write/delay/end entries into byte commands for a shared I2C byte engine.
module i2c_init_sequencer #(
    parameter int unsigned ADDR_W        = 6,
    parameter logic [7:0]  DEV_ADDR_CAM  = 8'h20,
    parameter logic [7:0]  DEV_ADDR_HDMI = 8'h72,
    parameter int unsigned MS_CYCLES     = 74250,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iGo,
    output logic              oBusy,
    output logic              oDone,
    output logic              oError,
    output logic [ADDR_W-1:0] ovErrIndex,
    output logic [ADDR_W-1:0] ovRomAddr,
    input  logic [39:0]       ivRomData,
    output logic              oByteValid,
    output logic              oByteStart,
    output logic              oByteStop,
    output logic [7:0]        ovByte,
    input  logic              iByteReady,
    input  logic              iByteDone,
    input  logic              iByteNack
);

    localparam int unsigned CYC_W = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam int unsigned RET_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(MS_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_FIRST = (MS_CYCLES > 1) ? CYC_W'(1) : '0;
    localparam logic [RET_W-1:0] RET_MAX   = RET_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_SEND, S_WAIT, S_DELAY, S_NEXT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  err_idx_q, err_idx_d;
    logic               err_q, err_d;
    logic               hdmi_q, hdmi_d;
    logic               wide_q, wide_d;
    logic [15:0]        reg_q, reg_d;
    logic [15:0]        data_q, data_d;
    logic [2:0]         idx_q, idx_d;
    logic [RET_W-1:0]   retry_q, retry_d;
    logic [15:0]        ms_q, ms_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;

    logic [2:0]         last_idx;
    logic [7:0]         byte_sel;
    logic               in_send;
    logic               unused_rsvd;

    assign unused_rsvd = ^ivRomData[35:32];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            err_idx_q <= '0;
            err_q     <= 1'b0;
            hdmi_q    <= 1'b0;
            wide_q    <= 1'b0;
            reg_q     <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            ms_q      <= '0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            err_idx_q <= err_idx_d;
            err_q     <= err_d;
            hdmi_q    <= hdmi_d;
            wide_q    <= wide_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            ms_q      <= ms_d;
            cyc_q     <= cyc_d;
        end
    end

    assign last_idx = wide_q ? 3'd4 : 3'd2;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        err_idx_d = err_idx_q;
        err_d     = err_q;
        hdmi_d    = hdmi_q;
        wide_d    = wide_q;
        reg_d     = reg_q;
        data_d    = data_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        ms_d      = ms_q;
        cyc_d     = cyc_q;
        case (state_q)
            S_IDLE: begin
                if (iGo) begin
                    err_d   = 1'b0;
                    addr_d  = '0;
                    retry_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                hdmi_d = ivRomData[37];
                wide_d = ivRomData[36];
                reg_d  = ivRomData[31:16];
                data_d = ivRomData[15:0];
                idx_d  = '0;
                ms_d   = ivRomData[15:0];
                // DECODE itself is the first cycle of a delay
                cyc_d  = CYC_FIRST;
                case (ivRomData[39:38])
                    2'b01:   state_d = S_SEND;
                    2'b10:   state_d = (ivRomData[15:0] == 16'd0) ? S_NEXT : S_DELAY;
                    default: state_d = S_DONE;
                endcase
            end
            S_SEND: begin
                if (iByteReady) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (iByteDone) begin
                    if (!iByteNack) begin
                        if (idx_q == last_idx) begin
                            state_d = S_NEXT;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_SEND;
                        end
                    end else if (retry_q < RET_MAX) begin
                        retry_d = retry_q + 1'b1;
                        idx_d   = '0;
                        state_d = S_SEND;
                    end else begin
                        err_d     = 1'b1;
                        err_idx_d = addr_q;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DELAY: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (ms_q == 16'd1) state_d = S_NEXT;
                    else               ms_d    = ms_q - 16'd1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (addr_q == '1) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_sel = hdmi_q ? DEV_ADDR_HDMI : DEV_ADDR_CAM;
        if (wide_q) begin
            case (idx_q)
                3'd0:    byte_sel = hdmi_q ? DEV_ADDR_HDMI : DEV_ADDR_CAM;
                3'd1:    byte_sel = reg_q[15:8];
                3'd2:    byte_sel = reg_q[7:0];
                3'd3:    byte_sel = data_q[15:8];
                default: byte_sel = data_q[7:0];
            endcase
        end else begin
            case (idx_q)
                3'd0:    byte_sel = hdmi_q ? DEV_ADDR_HDMI : DEV_ADDR_CAM;
                3'd1:    byte_sel = reg_q[7:0];
                default: byte_sel = data_q[7:0];
            endcase
        end
    end

    // Byte fields are gated so that every output reads 0 outside SEND
    assign in_send    = (state_q == S_SEND);
    assign oByteValid = in_send;
    assign oByteStart = in_send && (idx_q == 3'd0);
    assign oByteStop  = in_send && (idx_q == last_idx);
    assign ovByte     = in_send ? byte_sel : '0;

    assign oBusy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign oDone      = (state_q == S_DONE);
    assign oError     = err_q;
    assign ovErrIndex = err_idx_q;
    assign ovRomAddr  = addr_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench for i2c_init_sequencer: ROM model, byte-engine model with
// stall/NACK injection, expected byte stream queued per test.
module tb_i2c_init_sequencer;

    localparam int unsigned AW  = 6;
    localparam int          LAT = 4;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iGo;
    logic          oBusy, oDone, oError;
    logic [AW-1:0] ovErrIndex, ovRomAddr;
    logic [39:0]   ivRomData;
    logic          oByteValid, oByteStart, oByteStop;
    logic [7:0]    ovByte;
    logic          iByteReady, iByteDone, iByteNack;

    i2c_init_sequencer #(
        .ADDR_W    (AW),
        .MS_CYCLES (10),
        .MAX_RETRY (3)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iGo        (iGo),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oError     (oError),
        .ovErrIndex (ovErrIndex),
        .ovRomAddr  (ovRomAddr),
        .ivRomData  (ivRomData),
        .oByteValid (oByteValid),
        .oByteStart (oByteStart),
        .oByteStop  (oByteStop),
        .ovByte     (ovByte),
        .iByteReady (iByteReady),
        .iByteDone  (iByteDone),
        .iByteNack  (iByteNack)
    );

    always #5 iClk = ~iClk;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc_n = 0;
    int          g_cyc = 0;
    int          done_cnt = 0;
    int          max_addr = 0;
    int          t_addr [64];
    logic [39:0] rom [64];
    logic [9:0]  sb [$];
    int          stall_cfg = 0;
    int          nack_pos = -1;
    int          nack_match = -1;
    int          nack_left = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] mk_wr(input bit hdmi, input bit wide,
                                          input logic [15:0] r, input logic [15:0] d);
        return {2'b01, hdmi, wide, 4'hF, r, d};
    endfunction

    function automatic logic [39:0] mk_delay(input logic [15:0] ms);
        return {2'b10, 6'h00, 16'hFFFF, ms};
    endfunction

    // n == 0 pushes the whole entry; otherwise only the first n bytes of an aborted attempt
    task automatic push_entry(input bit hdmi, input bit wide, input logic [15:0] r,
                              input logic [15:0] d, input int n);
        logic [7:0] b [5];
        int last;
        int cnt;
        last = wide ? 4 : 2;
        cnt  = (n == 0) ? last + 1 : n;
        b[0] = hdmi ? 8'h72 : 8'h20;
        if (wide) begin
            b[1] = r[15:8]; b[2] = r[7:0]; b[3] = d[15:8]; b[4] = d[7:0];
        end else begin
            b[1] = r[7:0];  b[2] = d[7:0]; b[3] = 8'h00;   b[4] = 8'h00;
        end
        for (int i = 0; i < cnt; i++) sb.push_back({i == 0, i == last, b[i]});
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = '0;
    endtask

    task automatic go_pulse();
        @(negedge iClk);
        done_cnt = 0;
        max_addr = 0;
        iGo      = 1'b1;
        g_cyc    = cyc_n;
        @(negedge iClk);
        iGo      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            if (oDone) seen = 1'b1;
            else       @(negedge iClk);
        end
        check({tag, "_done_seen"}, seen, 1);
        repeat (2) @(negedge iClk);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_after"}, oBusy, 0);
    endtask

    initial forever @(posedge iClk) cyc_n++;

    // Synchronous ROM: data for the address seen before an edge appears after it
    initial begin : rom_model
        logic [AW-1:0] a;
        ivRomData = '0;
        forever begin
            @(negedge iClk);
            a = ovRomAddr;
            @(posedge iClk);
            #1 ivRomData = rom[a];
        end
    end

    initial begin : monitor
        logic [AW-1:0] prev;
        prev = '0;
        forever begin
            @(negedge iClk);
            if (oDone) done_cnt++;
            if (ovRomAddr != prev) begin
                t_addr[ovRomAddr] = cyc_n;
                prev = ovRomAddr;
            end
            if (oBusy && int'(ovRomAddr) > max_addr) max_addr = int'(ovRomAddr);
        end
    end

    initial begin : engine
        bit         in_pres, pend, nack_q;
        int         stall_left, lat_cnt, pos;
        logic [9:0] held, got, exp;
        iByteReady = 1'b1; iByteDone = 1'b0; iByteNack = 1'b0;
        in_pres = 1'b0; pend = 1'b0; nack_q = 1'b0;
        stall_left = 0; lat_cnt = 0; pos = 0; held = '0;
        forever begin
            @(negedge iClk);
            iByteDone = 1'b0;
            iByteNack = 1'b0;
            if (iRst) begin
                in_pres = 1'b0; pend = 1'b0; iByteReady = 1'b1;
            end else if (pend) begin
                if (lat_cnt == 0) begin
                    iByteDone = 1'b1; iByteNack = nack_q; pend = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end else if (oByteValid) begin
                got = {oByteStart, oByteStop, ovByte};
                if (!in_pres) begin
                    in_pres = 1'b1; held = got; stall_left = stall_cfg;
                end else begin
                    check("hold_stable", got, held);
                end
                if (stall_left > 0) begin
                    iByteReady = 1'b0;
                    stall_left--;
                end else begin
                    iByteReady = 1'b1;
                    in_pres    = 1'b0;
                    if (sb.size() > 0) exp = sb.pop_front();
                    else               exp = 10'h3FF;
                    check("byte", got, exp);
                    pos    = oByteStart ? 0 : pos + 1;
                    nack_q = (nack_left > 0) && (pos == nack_pos) &&
                             (nack_match < 0 || int'(ovByte) == nack_match);
                    if (nack_q) nack_left--;
                    pend    = 1'b1;
                    lat_cnt = LAT - 1;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  d2, d0;
        bit  seen;
        iRst = 1'b1;
        iGo  = 1'b0;
        clear_rom();
        repeat (3) @(negedge iClk);
        check("rst_busy", oBusy, 0);
        check("rst_done", oDone, 0);
        check("rst_err", oError, 0);
        check("rst_addr", ovRomAddr, 0);
        check("rst_byte_if", {oByteValid, oByteStart, oByteStop, ovByte}, 0);
        iRst = 1'b0;
        repeat (2) @(negedge iClk);

        // narrow HDMI write; upper reg/data bytes must be ignored
        clear_rom();
        rom[0] = mk_wr(1'b1, 1'b0, 16'hEE41, 16'hDD10);
        push_entry(1'b1, 1'b0, 16'hEE41, 16'hDD10, 0);
        go_pulse();
        check("t1_busy", oBusy, 1);
        wait_done("t1", 500);
        check("t1_err", oError, 0);
        check("t1_sb_left", sb.size(), 0);

        // wide cam write with 5-cycle ready stall per byte
        stall_cfg = 5;
        clear_rom();
        rom[0] = mk_wr(1'b0, 1'b1, 16'h301A, 16'h10DC);
        push_entry(1'b0, 1'b1, 16'h301A, 16'h10DC, 0);
        go_pulse();
        wait_done("t2", 1000);
        check("t2_err", oError, 0);
        check("t2_sb_left", sb.size(), 0);
        stall_cfg = 0;

        // NACK on 2nd byte twice, then success
        nack_pos = 1; nack_match = -1; nack_left = 2;
        clear_rom();
        rom[0] = mk_wr(1'b1, 1'b0, 16'h0041, 16'h0010);
        push_entry(1'b1, 1'b0, 16'h0041, 16'h0010, 2);
        push_entry(1'b1, 1'b0, 16'h0041, 16'h0010, 2);
        push_entry(1'b1, 1'b0, 16'h0041, 16'h0010, 0);
        go_pulse();
        wait_done("t3", 1000);
        check("t3_err", oError, 0);
        check("t3_nacks_used", nack_left, 0);
        check("t3_sb_left", sb.size(), 0);

        // persistent NACK at index 5 aborts after 4 attempts
        nack_pos = 1; nack_match = 8'h55; nack_left = 100;
        clear_rom();
        for (int i = 0; i < 5; i++) begin
            rom[i] = mk_wr(1'b0, 1'b0, 16'(8'h10 + i), 16'(i));
            push_entry(1'b0, 1'b0, 16'(8'h10 + i), 16'(i), 0);
        end
        rom[5] = mk_wr(1'b0, 1'b0, 16'h0055, 16'h00AA);
        rom[6] = mk_wr(1'b0, 1'b0, 16'h0066, 16'h0000);
        for (int i = 0; i < 4; i++) push_entry(1'b0, 1'b0, 16'h0055, 16'h00AA, 2);
        go_pulse();
        wait_done("t4", 3000);
        check("t4_err", oError, 1);
        check("t4_err_idx", ovErrIndex, 5);
        check("t4_max_addr", max_addr, 5);
        check("t4_sb_left", sb.size(), 0);
        nack_left = 0;

        // 2 ms delay, 0 ms delay, then a write
        clear_rom();
        rom[0] = mk_delay(16'd2);
        rom[1] = mk_delay(16'd0);
        rom[2] = mk_wr(1'b0, 1'b0, 16'h0077, 16'h0088);
        push_entry(1'b0, 1'b0, 16'h0077, 16'h0088, 0);
        go_pulse();
        check("t5_err_cleared", oError, 0);
        wait_done("t5", 1000);
        d2 = t_addr[1] - (g_cyc + 2);
        d0 = t_addr[2] - t_addr[1];
        check("t5_dly2_lat", (d2 >= 19 && d2 <= 21) ? 20 : d2, 20);
        check("t5_dly0_lat", d0, 3);
        check("t5_sb_left", sb.size(), 0);

        // reset while a byte is stalled in SEND, then restart from index 0
        stall_cfg = 50;
        clear_rom();
        rom[0] = mk_wr(1'b0, 1'b0, 16'h0012, 16'h0034);
        rom[1] = mk_wr(1'b1, 1'b1, 16'hABCD, 16'h0102);
        go_pulse();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (oByteValid) seen = 1'b1;
            else            @(negedge iClk);
        end
        check("t6_send_seen", seen, 1);
        repeat (2) @(negedge iClk);
        iRst = 1'b1;
        #1;
        check("t6_rst_byte_if", {oByteValid, oByteStart, oByteStop, ovByte}, 0);
        check("t6_rst_busy", oBusy, 0);
        check("t6_rst_addr", ovRomAddr, 0);
        check("t6_rst_erridx", ovErrIndex, 0);
        stall_cfg = 0;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        push_entry(1'b0, 1'b0, 16'h0012, 16'h0034, 0);
        push_entry(1'b1, 1'b1, 16'hABCD, 16'h0102, 0);
        go_pulse();
        repeat (3) @(negedge iClk);
        iGo = 1'b1;
        @(negedge iClk);
        iGo = 1'b0;
        wait_done("t6", 1000);
        check("t6_err", oError, 0);
        check("t6_sb_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
